ipu_input: RTL and testbench

Input processing unit front end for the tic-tac-toe system. It synchronises and debounces the player's "enter" button and samples the 4-bit cell selection from the switches. A valid selection is written into `grid_coord` through `write_en`/`coord_out`. The block then raises `ipu_int` to `proc` and holds it until `proc` returns `int_ack`. It sits directly upstream of `grid_coord` and `proc`.

---
 rtl/ipu_input.sv | 138 +++++++++++++
 tb/tb_ipu_input.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/ipu_input.sv
// Tic-tac-toe input front end: synchronises/debounces the enter button, samples the
// cell selection, writes it to grid_coord and holds an interrupt to proc until acked.
module ipu_input #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned MAX_COORD       = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sw,
  input  logic       btn,
  input  logic       int_ack,
  output logic       write_en,
  output logic [3:0] coord_out,
  output logic       ipu_int,
  output logic       bad_coord,
  output logic       busy
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]       COORD_MAX = 4'(MAX_COORD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_CAPTURE,
    S_INT_PEND,
    S_RELEASE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [3:0]       r_coord_q;
  logic [3:0]       w_coord_nxt;
  logic             w_btn_s;
  logic             w_cnt_last;
  logic             w_capture_ok;
  logic             w_capture_bad;

  assign w_btn_s    = r_sync[1];
  assign w_cnt_last = (r_cnt == CNT_LAST);

  // Two-flop synchroniser for the asynchronous button.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], btn};
    end
  end

  // Reset lands in RELEASE so a button held through reset is not taken as a press.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_RELEASE;
      r_cnt     <= '0;
      r_coord_q <= 4'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_coord_q <= w_coord_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_coord_nxt = r_coord_q;
    case (r_state)
      S_IDLE: begin
        if (w_btn_s) begin
          w_state_nxt = S_DEBOUNCE;
          w_cnt_nxt   = '0;
        end
      end
      S_DEBOUNCE: begin
        if (!w_btn_s) begin
          w_state_nxt = S_IDLE;
        end else if (w_cnt_last) begin
          w_state_nxt = S_CAPTURE;
          w_coord_nxt = sw;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        // Counter is left at its terminal value by DEBOUNCE; RELEASE needs it cleared.
        w_cnt_nxt   = '0;
        w_state_nxt = (r_coord_q <= COORD_MAX) ? S_INT_PEND : S_RELEASE;
      end
      S_INT_PEND: begin
        if (int_ack) begin
          w_state_nxt = S_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      S_RELEASE: begin
        if (w_btn_s) begin
          w_cnt_nxt = '0;
        end else if (w_cnt_last) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_RELEASE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_capture_ok  = (w_state_nxt == S_CAPTURE) && (w_coord_nxt <= COORD_MAX);
  assign w_capture_bad = (w_state_nxt == S_CAPTURE) && (w_coord_nxt >  COORD_MAX);

  // Outputs registered from the next state so they align with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en  <= 1'b0;
      coord_out <= 4'd0;
      ipu_int   <= 1'b0;
      bad_coord <= 1'b0;
      busy      <= 1'b1;
    end else begin
      write_en  <= w_capture_ok;
      bad_coord <= w_capture_bad;
      ipu_int   <= (w_state_nxt == S_INT_PEND);
      busy      <= (w_state_nxt != S_IDLE);
      if (w_capture_ok) begin
        coord_out <= w_coord_nxt;
      end
    end
  end

endmodule

// File: tb/tb_ipu_input.sv
// Directed bench for ipu_input with D=4, MAX_COORD=8; edge numbers are relative to
// the first rising edge that sees btn high.
module tb_ipu_input;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic       btn;
  logic       int_ack;
  logic       write_en;
  logic [3:0] coord_out;
  logic       ipu_int;
  logic       bad_coord;
  logic       busy;

  int checks = 0;
  int errors = 0;

  ipu_input #(.DEBOUNCE_CYCLES(4), .MAX_COORD(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw        (sw),
    .btn       (btn),
    .int_ack   (int_ack),
    .write_en  (write_en),
    .coord_out (coord_out),
    .ipu_int   (ipu_int),
    .bad_coord (bad_coord),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [11:0] pat;
    logic        saw_we;
    logic        saw_int;
    logic        saw_bad;
    logic        saw_busy;
    logic        saw_int_low;

    rst = 1'b0; btn = 1'b0; sw = 4'd0; int_ack = 1'b0;

    // Reset values, then busy drops D edges after reset release.
    tick(3);
    chk1("rst_we", write_en, 1'b0);
    chk4("rst_coord", coord_out, 4'd0);
    chk1("rst_int", ipu_int, 1'b0);
    chk1("rst_bad", bad_coord, 1'b0);
    chk1("rst_busy", busy, 1'b1);
    rst = 1'b1;
    tick(3);
    chk1("rel_busy_hold", busy, 1'b1);
    tick(1);
    chk1("rel_busy_fall", busy, 1'b0);

    // Valid press: sw=2, btn high for edges 0..19, ack at edge 10.
    sw = 4'd2; btn = 1'b1;
    tick(3);
    chk1("p1_busy_e2", busy, 1'b1);
    chk1("p1_we_e2", write_en, 1'b0);
    tick(3);
    chk1("p1_we_e5", write_en, 1'b0);
    tick(1);
    chk1("p1_we_e6", write_en, 1'b1);
    chk4("p1_coord_e6", coord_out, 4'd2);
    chk1("p1_int_e6", ipu_int, 1'b0);
    chk1("p1_bad_e6", bad_coord, 1'b0);
    tick(1);
    chk1("p1_we_e7", write_en, 1'b0);
    chk1("p1_int_e7", ipu_int, 1'b1);
    tick(2);
    chk1("p1_int_e9", ipu_int, 1'b1);
    int_ack = 1'b1;
    tick(1);
    chk1("p1_int_e10", ipu_int, 1'b0);
    chk1("p1_busy_e10", busy, 1'b1);
    int_ack = 1'b0;
    tick(9);
    btn = 1'b0;
    tick(5);
    chk1("p1_busy_e24", busy, 1'b1);
    tick(1);
    chk1("p1_busy_e25", busy, 1'b0);
    chk4("p1_coord_hold", coord_out, 4'd2);

    // Bounce: high 3, low 1, high 2, then low; must abort with no output activity.
    pat = 12'b0000_0011_0111;
    saw_we = 1'b0; saw_int = 1'b0; saw_bad = 1'b0; saw_busy = 1'b0;
    sw = 4'd6;
    btn = pat[0];
    for (int i = 0; i < 12; i++) begin
      tick(1);
      saw_we   = saw_we | write_en;
      saw_int  = saw_int | ipu_int;
      saw_bad  = saw_bad | bad_coord;
      saw_busy = saw_busy | busy;
      if (i < 11) btn = pat[i+1];
      else btn = 1'b0;
    end
    chk1("bnc_no_we", saw_we, 1'b0);
    chk1("bnc_no_int", saw_int, 1'b0);
    chk1("bnc_no_bad", saw_bad, 1'b0);
    chk1("bnc_saw_busy", saw_busy, 1'b1);
    chk1("bnc_busy_end", busy, 1'b0);

    // Out-of-range selection 11.
    sw = 4'd11; btn = 1'b1;
    tick(6);
    chk1("bad_pre_e5", bad_coord, 1'b0);
    tick(1);
    chk1("bad_e6", bad_coord, 1'b1);
    chk1("bad_we_e6", write_en, 1'b0);
    chk4("bad_coord_keep", coord_out, 4'd2);
    tick(1);
    chk1("bad_e7", bad_coord, 1'b0);
    chk1("bad_int_e7", ipu_int, 1'b0);
    chk1("bad_we_e7", write_en, 1'b0);
    tick(2);
    btn = 1'b0;
    tick(5);
    chk1("bad_busy_e14", busy, 1'b1);
    tick(1);
    chk1("bad_busy_e15", busy, 1'b0);

    // int_ack held high throughout: ack ignored in CAPTURE, ipu_int high one cycle.
    int_ack = 1'b1; sw = 4'd5; btn = 1'b1;
    tick(7);
    chk1("ackh_we_e6", write_en, 1'b1);
    chk4("ackh_coord_e6", coord_out, 4'd5);
    tick(1);
    chk1("ackh_int_e7", ipu_int, 1'b1);
    tick(1);
    chk1("ackh_int_e8", ipu_int, 1'b0);
    tick(1);
    btn = 1'b0; int_ack = 1'b0;
    tick(6);
    chk1("ackh_busy_end", busy, 1'b0);

    // Second press during INT_PEND is ignored.
    sw = 4'd3; btn = 1'b1;
    tick(7);
    chk1("p2_we_e6", write_en, 1'b1);
    chk4("p2_coord_e6", coord_out, 4'd3);
    tick(1);
    chk1("p2_int_e7", ipu_int, 1'b1);
    tick(2);
    btn = 1'b0;
    tick(3);
    btn = 1'b1; sw = 4'd8;
    saw_we = 1'b0; saw_int_low = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      saw_we      = saw_we | write_en;
      saw_int_low = saw_int_low | ~ipu_int;
    end
    chk1("p2_no_we", saw_we, 1'b0);
    chk1("p2_int_held", saw_int_low, 1'b0);
    chk4("p2_coord_keep", coord_out, 4'd3);

    // Reset mid-INT_PEND with btn held: async clear, no press until released.
    rst = 1'b0;
    #2;
    chk1("ar_int", ipu_int, 1'b0);
    chk1("ar_we", write_en, 1'b0);
    chk1("ar_busy", busy, 1'b1);
    chk4("ar_coord", coord_out, 4'd0);
    tick(2);
    rst = 1'b1; sw = 4'd4;
    saw_we = 1'b0; saw_int = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick(1);
      saw_we  = saw_we | write_en;
      saw_int = saw_int | ipu_int;
    end
    chk1("ar_no_we", saw_we, 1'b0);
    chk1("ar_no_int", saw_int, 1'b0);
    chk1("ar_busy_held", busy, 1'b1);
    btn = 1'b0;
    tick(5);
    chk1("ar_busy_e5", busy, 1'b1);
    tick(1);
    chk1("ar_busy_e6", busy, 1'b0);

    // Fresh press after release is accepted.
    sw = 4'd7; btn = 1'b1;
    tick(7);
    chk1("p3_we_e6", write_en, 1'b1);
    chk4("p3_coord_e6", coord_out, 4'd7);
    tick(1);
    chk1("p3_int_e7", ipu_int, 1'b1);
    int_ack = 1'b1;
    tick(1);
    chk1("p3_int_e8", ipu_int, 1'b0);
    int_ack = 1'b0; btn = 1'b0;
    tick(8);
    chk1("p3_busy_end", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
